// File: rtl/ip_codma_machine_states_pkg.sv
// Shared state encodings and sizing constants for CoDMA control machines.
// The CRC loader imports its block geometry and state enum from here.
package ip_codma_machine_states_pkg;

    localparam int CRC_BLOCK_WORDS = 8;
    localparam int CRC_WIDTH       = 16;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        START,
        WAIT,
        DONE
    } crc_loader_state_t;

endpackage

// File: rtl/ip_codma_crc_loader.sv
// Gathers DMA read words into a block for the CRC engine, kicks the engine,
// and hands the 16-bit CRC (or a timeout abort) back to the DMA controller.
module ip_codma_crc_loader
    import ip_codma_machine_states_pkg::*;
#(
    parameter int NUM_WORDS      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [31:0]                          word_i,
    input  logic                                 word_valid_i,
    input  logic                                 word_last_i,
    output logic                                 word_ready_o,
    output logic [CRC_BLOCK_WORDS-1:0][31:0]     data_reg_o,
    output logic                                 crc_start_o,
    input  logic                                 crc_complete_flag_i,
    input  logic [CRC_BLOCK_WORDS-1:0][31:0]     crc_output_i,
    output logic [CRC_WIDTH-1:0]                 crc_result_o,
    output logic                                 result_valid_o,
    input  logic                                 result_ready_i,
    output logic                                 busy_o,
    output logic                                 err_timeout_o
);

    localparam logic [2:0]  LAST_IDX = 3'(NUM_WORDS - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    crc_loader_state_t                    state_q, state_d;
    logic [2:0]                           cnt_q, cnt_d;
    logic [15:0]                          tcnt_q, tcnt_d;
    logic [CRC_BLOCK_WORDS-1:0][31:0]     data_q, data_d;
    logic [CRC_WIDTH-1:0]                 crc_q, crc_d;
    logic                                 err_q, err_d;

    logic accepting;
    logic word_hs;
    logic fill_end;
    logic unused_ok;

    // Only the low CRC_WIDTH bits of engine word 0 carry the result.
    assign unused_ok = ^{crc_output_i[CRC_BLOCK_WORDS-1:1], crc_output_i[0][31:CRC_WIDTH]};

    assign accepting = (state_q == IDLE) || (state_q == FILL);
    assign word_hs   = accepting && word_valid_i;
    assign fill_end  = word_last_i || (cnt_q == LAST_IDX);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            data_q  <= '0;
            crc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            data_q  <= data_d;
            crc_q   <= crc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (word_hs) state_d = (word_last_i || NUM_WORDS == 1) ? START : FILL;
            FILL:    if (word_hs && fill_end) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (crc_complete_flag_i || tcnt_q == TO_LAST) state_d = DONE;
            DONE:    if (result_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        tcnt_d = tcnt_q;
        data_d = data_q;
        crc_d  = crc_q;
        err_d  = err_q;
        case (state_q)
            IDLE: begin
                if (word_hs) begin
                    data_d    = '0;
                    data_d[0] = word_i;
                    cnt_d     = 3'd1;
                end
            end
            FILL: begin
                if (word_hs) begin
                    data_d[cnt_q] = word_i;
                    if (!fill_end) cnt_d = cnt_q + 3'd1;
                end
            end
            START: tcnt_d = '0;
            WAIT: begin
                // A completion arriving on the last allowed cycle still counts as success.
                if (crc_complete_flag_i) begin
                    crc_d = crc_output_i[0][CRC_WIDTH-1:0];
                    err_d = 1'b0;
                end else if (tcnt_q == TO_LAST) begin
                    crc_d = '0;
                    err_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    data_d = '0;
                    crc_d  = '0;
                    err_d  = 1'b0;
                    cnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        // Ready is forced low while reset is held so every output reads zero.
        word_ready_o   = accepting && reset_n_i;
        crc_start_o    = (state_q == START);
        result_valid_o = (state_q == DONE);
        busy_o         = (state_q != IDLE);
        data_reg_o     = data_q;
        crc_result_o   = crc_q;
        err_timeout_o  = err_q;
    end

endmodule

// File: tb/tb_ip_codma_crc_loader.sv
// Bench for the CRC loader: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a queue-based model.
module tb_ip_codma_crc_loader;

    localparam int NW = 8;
    localparam int TO = 16;

    logic              clk_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic [31:0]       word_i = '0;
    logic              word_valid_i = 1'b0;
    logic              word_last_i = 1'b0;
    logic              word_ready_o;
    logic [7:0][31:0]  data_reg_o;
    logic              crc_start_o;
    logic              crc_complete_flag_i = 1'b0;
    logic [7:0][31:0]  crc_output_i = '0;
    logic [15:0]       crc_result_o;
    logic              result_valid_o;
    logic              result_ready_i = 1'b0;
    logic              busy_o;
    logic              err_timeout_o;

    int checks = 0;
    int failures = 0;

    ip_codma_crc_loader #(.NUM_WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n_i),
        .word_i              (word_i),
        .word_valid_i        (word_valid_i),
        .word_last_i         (word_last_i),
        .word_ready_o        (word_ready_o),
        .data_reg_o          (data_reg_o),
        .crc_start_o         (crc_start_o),
        .crc_complete_flag_i (crc_complete_flag_i),
        .crc_output_i        (crc_output_i),
        .crc_result_o        (crc_result_o),
        .result_valid_o      (result_valid_o),
        .result_ready_i      (result_ready_i),
        .busy_o              (busy_o),
        .err_timeout_o       (err_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: the accepted words of the current block live in a queue.
    bit          m_acc = 1'b1;
    bit          m_start = 1'b0;
    bit          m_wait = 1'b0;
    bit          m_done = 1'b0;
    int          m_n = 0;
    logic [15:0] m_res = '0;
    bit          m_err = 1'b0;
    logic [31:0] blk[$];

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_acc = 1'b1; m_start = 1'b0; m_wait = 1'b0; m_done = 1'b0;
            m_n = 0; m_res = '0; m_err = 1'b0;
            blk.delete();
        end else if (m_acc) begin
            if (word_valid_i) begin
                blk.push_back(word_i);
                if (word_last_i || blk.size() == NW) begin
                    m_acc = 1'b0;
                    m_start = 1'b1;
                end
            end
        end else if (m_start) begin
            m_start = 1'b0;
            m_wait = 1'b1;
            m_n = 0;
        end else if (m_wait) begin
            if (crc_complete_flag_i) begin
                m_res = crc_output_i[0][15:0]; m_err = 1'b0; m_wait = 1'b0; m_done = 1'b1;
            end else if (m_n == TO - 1) begin
                m_res = '0; m_err = 1'b1; m_wait = 1'b0; m_done = 1'b1;
            end else begin
                m_n++;
            end
        end else if (m_done && result_ready_i) begin
            m_done = 1'b0; m_res = '0; m_err = 1'b0; m_acc = 1'b1;
            blk.delete();
        end
    end

    always @(negedge clk_i) begin
        logic [7:0][31:0] ed;
        for (int i = 0; i < 8; i++) ed[i] = (i < blk.size()) ? blk[i] : 32'h0;
        chk("cmp_ready", word_ready_o, m_acc && reset_n_i);
        chk("cmp_start", crc_start_o, m_start);
        chk("cmp_busy", busy_o, !(m_acc && blk.size() == 0));
        chk("cmp_valid", result_valid_o, m_done);
        chk("cmp_data", data_reg_o, ed);
        chk("cmp_crc", crc_result_o, m_done ? m_res : 16'h0);
        chk("cmp_err", err_timeout_o, m_done ? m_err : 1'b0);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        word_valid_i = 1'b0; word_last_i = 1'b0;
        crc_complete_flag_i = 1'b0; result_ready_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, word_ready_o, 1'b0);
        chk({nm, "_start"}, crc_start_o, 1'b0);
        chk({nm, "_busy"}, busy_o, 1'b0);
        chk({nm, "_valid"}, result_valid_o, 1'b0);
        chk({nm, "_err"}, err_timeout_o, 1'b0);
        chk({nm, "_crc"}, crc_result_o, 16'h0);
        chk({nm, "_data"}, data_reg_o, 256'h0);
    endtask

    task automatic send_full(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            word_i = base + 32'(i); word_valid_i = 1'b1; word_last_i = (i == 7);
            tick();
        end
        word_valid_i = 1'b0; word_last_i = 1'b0;
    endtask

    task automatic release_result();
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    initial begin
        #7;
        chk_all_zero("rst");
        tick();
        reset_n_i = 1'b1;
        tick();
        chk("idle_ready", word_ready_o, 1'b1);

        // Full block, engine flag seen on the third WAIT cycle.
        send_full(32'h1);
        chk("fb_start", crc_start_o, 1'b1);
        chk("fb_busy", busy_o, 1'b1);
        tick();
        chk("fb_start_once", crc_start_o, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) chk($sformatf("fb_data%0d", i), data_reg_o[i], 32'(i + 1));
            if (k == 2) begin crc_complete_flag_i = 1'b1; crc_output_i[0] = 32'h0000BEEF; end
            tick();
        end
        crc_complete_flag_i = 1'b0;
        chk("fb_valid", result_valid_o, 1'b1);
        chk("fb_crc", crc_result_o, 16'hBEEF);
        chk("fb_err", err_timeout_o, 1'b0);
        release_result();
        chk("fb_idle_valid", result_valid_o, 1'b0);
        chk("fb_idle_data", data_reg_o, 256'h0);

        // Early last after three words; flag already high during START must not count.
        word_valid_i = 1'b1;
        word_i = 32'hAAAA5555; tick();
        word_i = 32'h12345678; tick();
        word_i = 32'hFFFFFFFF; word_last_i = 1'b1; tick();
        word_valid_i = 1'b0; word_last_i = 1'b0;
        chk("el_start", crc_start_o, 1'b1);
        chk("el_d0", data_reg_o[0], 32'hAAAA5555);
        chk("el_d2", data_reg_o[2], 32'hFFFFFFFF);
        chk("el_hi_zero", data_reg_o[7:3], 160'h0);
        crc_complete_flag_i = 1'b1; crc_output_i[0] = 32'h1234CAFE;
        tick();
        chk("el_wait_valid", result_valid_o, 1'b0);
        tick();
        crc_complete_flag_i = 1'b0;
        crc_output_i[0] = 32'h0;

        // Result backpressure.
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", result_valid_o, 1'b1);
            chk("bp_crc", crc_result_o, 16'hCAFE);
            chk("bp_ready", word_ready_o, 1'b0);
            chk("bp_busy", busy_o, 1'b1);
            tick();
        end
        release_result();
        chk("bp_rel_valid", result_valid_o, 1'b0);
        chk("bp_rel_busy", busy_o, 1'b0);
        chk("bp_rel_data", data_reg_o, 256'h0);

        // Timeout: engine silent for the full budget.
        word_i = 32'h55; word_valid_i = 1'b1; word_last_i = 1'b1; tick();
        word_valid_i = 1'b0; word_last_i = 1'b0;
        crc_output_i[0] = 32'hDEADBEEF;
        tick();
        for (int k = 0; k < TO; k++) begin
            chk("to_wait_valid", result_valid_o, 1'b0);
            tick();
        end
        chk("to_valid", result_valid_o, 1'b1);
        chk("to_err", err_timeout_o, 1'b1);
        chk("to_crc", crc_result_o, 16'h0);
        release_result();
        chk("to_err_clr", err_timeout_o, 1'b0);

        // Asynchronous reset in the middle of WAIT, then a clean block.
        send_full(32'h100);
        for (int k = 0; k < 5; k++) tick();
        #3;
        reset_n_i = 1'b0;
        #1;
        chk_all_zero("mr");
        tick();
        reset_n_i = 1'b1;
        tick();
        send_full(32'h200);
        tick();
        crc_complete_flag_i = 1'b1; crc_output_i[0] = 32'h00007A11;
        tick();
        crc_complete_flag_i = 1'b0;
        chk("mr_valid", result_valid_o, 1'b1);
        chk("mr_crc", crc_result_o, 16'h7A11);
        chk("mr_d7", data_reg_o[7], 32'h207);
        release_result();

        // Gapped input; last pulses without valid are ignored.
        for (int i = 0; i < 15; i++) begin
            if (i % 2 == 0) begin
                word_valid_i = 1'b1; word_i = 32'h300 + 32'(i / 2); word_last_i = (i == 14);
            end else begin
                word_valid_i = 1'b0; word_i = 32'hBAD0BAD0; word_last_i = 1'b1;
            end
            tick();
        end
        word_valid_i = 1'b0; word_last_i = 1'b0;
        chk("gap_start", crc_start_o, 1'b1);
        for (int i = 0; i < 8; i++) chk($sformatf("gap_d%0d", i), data_reg_o[i], 32'h300 + 32'(i));
        crc_complete_flag_i = 1'b1;
        tick(); tick();
        crc_complete_flag_i = 1'b0;
        release_result();

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int c = 0; c < 2500; c++) begin
            word_i              = $urandom;
            word_valid_i        = ($urandom_range(0, 99) < 60);
            word_last_i         = ($urandom_range(0, 99) < 25);
            crc_complete_flag_i = ($urandom_range(0, 99) < 12);
            for (int i = 0; i < 8; i++) crc_output_i[i] = $urandom;
            result_ready_i      = ($urandom_range(0, 99) < 50);
            tick();
        end
        idle_in();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ip_codma_crc_loader.md
Name: ip_codma_crc_loader

Overview:
- Upstream feeder for the CoDMA CRC engine.
- Collects 32-bit words from the DMA read datapath over a valid/ready handshake into an 8-word block register.
- Presents the block to the CRC engine, pulses a start strobe, and holds the block stable until the engine raises its completion flag.
- Returns the 16-bit CRC to the DMA controller on a valid/ready result handshake, with a timeout error if the engine never completes.

Parameters:
- NUM_WORDS, 8, words per CRC block; legal range 1..8; words above NUM_WORDS-1 are always zero.
- TIMEOUT_CYCLES, 256, maximum cycles spent in WAIT before abort; legal range 2..65535.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous reset, active-low.
- word_i  in  32  data word from the DMA read path.
- word_valid_i  in  1  word_i is valid.
- word_last_i  in  1  qualifies word_i as the final word of the block (early termination).
- word_ready_o  out  1  loader accepts word_i this cycle.
- data_reg_o  out  [7:0][31:0]  block presented to the CRC engine data_reg input.
- crc_start_o  out  1  one-cycle start pulse to the CRC engine.
- crc_complete_flag_i  in  1  engine completion flag (level).
- crc_output_i  in  [7:0][31:0]  engine result; CRC is crc_output_i[0][15:0].
- crc_result_o  out  16  captured CRC.
- result_valid_o  out  1  crc_result_o and err_timeout_o are valid.
- result_ready_i  in  1  consumer takes the result.
- busy_o  out  1  high in every state except IDLE.
- err_timeout_o  out  1  result aborted by timeout; qualified by result_valid_o.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, data_reg_o all zero, state IDLE, word counter 0, timeout counter 0. Reset asserted mid-operation discards the block; no result is produced.
- States (crc_loader_state_t): IDLE, FILL, START, WAIT, DONE.
- IDLE:
  - word_ready_o=1.
  - A handshake (valid & ready) writes word_i to data_reg_o[0] and zeroes words 1..7 in the same cycle.
  - Counter becomes 1; go to FILL.
  - If word_last_i is high or NUM_WORDS==1, go to START instead.
- FILL:
  - word_ready_o=1.
  - Each handshake writes data_reg_o[cnt] and increments cnt.
  - Go to START on the handshake where word_last_i=1 or cnt==NUM_WORDS-1.
  - Unfilled words stay zero.
- START:
  - word_ready_o=0; crc_start_o=1 for exactly this cycle; timeout counter cleared.
  - Go to WAIT.
- WAIT:
  - data_reg_o held stable.
  - crc_complete_flag_i is ignored in START and sampled only from the first WAIT cycle.
  - If the flag is high: capture crc_output_i[0][15:0] into crc_result_o, err_timeout_o=0, go to DONE.
  - Else increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 without the flag: crc_result_o=16'h0000, err_timeout_o=1, go to DONE.
  - Flag and timeout in the same cycle: the flag wins, no error.
- DONE:
  - result_valid_o=1; crc_result_o and err_timeout_o held until result_ready_i.
  - On handshake: result_valid_o=0 next cycle, err_timeout_o cleared, data_reg_o cleared to zero, go to IDLE.
  - A new word is not accepted in the handshake cycle (word_ready_o=0 in DONE).
- Latency:
  - Last word accepted at cycle T gives crc_start_o at T+1.
  - Flag first seen in WAIT at cycle T+2+k gives result_valid_o at T+3+k.
- Throughput: one word per cycle in IDLE/FILL; back-to-back blocks are separated by at least the DONE→IDLE cycle.
- word_i, word_last_i and word_valid_i are ignored when word_ready_o=0. word_last_i without word_valid_i has no effect.
- Counter width is 3 bits; it never wraps because FILL exits at NUM_WORDS-1. Timeout counter width is 16 bits.

Decomposition:
- ip_codma_machine_states_pkg gains:
  - crc_loader_state_t enum {IDLE, FILL, START, WAIT, DONE}.
  - CRC_BLOCK_WORDS = 8.
  - CRC_WIDTH = 16.
- Single module; no sub-module. The timeout counter is inline.

Test Plan:
- Full block: 8 words 0x00000001..0x00000008, valid every cycle, last on word 8; engine flag 3 cycles after start with crc_output_i[0]=0x0000BEEF → data_reg_o[i]=i+1, one crc_start_o pulse, crc_result_o=0xBEEF, err_timeout_o=0, data_reg_o stable throughout WAIT.
- Early last: 3 words 0xAAAA5555, 0x12345678, 0xFFFFFFFF with last on word 3 → data_reg_o[3..7]=0, start pulse on the cycle after word 3.
- Backpressure: hold result_ready_i=0 for 10 cycles in DONE → result_valid_o and crc_result_o held, word_ready_o=0, busy_o=1; release → IDLE next cycle, data_reg_o zero.
- Timeout: TIMEOUT_CYCLES=16, engine never flags → result_valid_o with err_timeout_o=1 and crc_result_o=0x0000, exactly 16 cycles after entering WAIT.
- Reset mid-WAIT: assert reset_n_i=0 asynchronously after 5 WAIT cycles → all outputs 0 immediately; after release a fresh 8-word block completes normally.
- Gapped input: word_valid_i toggled 1/0 over 8 words → word order preserved in data_reg_o[0..7]; a word_last_i pulse with word_valid_i=0 is ignored.
